// File: rtl/frame_router.sv
// frame_router: routes one frame of data beats from a single input stream to
// one of NCH AXI-Stream outputs, selected by a per-frame metadata beat.
// Frames addressed to a missing channel, or of zero length, are consumed and
// counted as dropped. The data path is combinational; only control is registered.
module frame_router #(
   parameter int DW  = 512,
   parameter int NCH = 4,
   parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         frame_size,
   input  logic [DW-1:0]       axis_md_tdata,
   input  logic                axis_md_tvalid,
   output logic                axis_md_tready,
   input  logic [DW-1:0]       axis_df_tdata,
   input  logic                axis_df_tvalid,
   output logic                axis_df_tready,
   output logic [NCH*DW-1:0]   axis_out_tdata,
   output logic [NCH*DW/8-1:0] axis_out_tkeep,
   output logic [NCH-1:0]      axis_out_tlast,
   output logic [NCH-1:0]      axis_out_tvalid,
   input  logic [NCH-1:0]      axis_out_tready,
   output logic                busy,
   output logic [31:0]         frames_routed,
   output logic [31:0]         frames_dropped
);

   localparam int KW  = DW / 8;                 // bytes per beat
   localparam int OW  = $clog2(KW);             // byte-offset width
   localparam int RW  = (OW > 0) ? OW : 1;      // storage width of the remainder

   typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

   state_t          state;
   logic [CHW-1:0]  chan_q;
   logic [31:0]     beats_left;
   logic [RW-1:0]   rem_q;

   logic [RW-1:0]   rem_next;
   logic [31:0]     beats_next;
   logic            last_beat;
   logic            sel_ready;
   logic [KW-1:0]   keep_last;
   logic            md_unused;

   // Only the channel byte of the metadata word carries information.
   assign md_unused = ^axis_md_tdata[DW-1:8];

   // Frame geometry from the byte count: a partial final beat adds one beat.
   assign rem_next   = RW'(frame_size & 32'(KW - 1));
   assign beats_next = (frame_size >> OW) + 32'(rem_next != '0);
   assign last_beat  = (beats_left == 32'd1);
   assign keep_last  = (rem_q == '0) ? '1 : ((KW'(1) << rem_q) - KW'(1));

   // Ready of the currently selected output channel.
   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_ready = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (chan_q == CHW'(c)) sel_ready = axis_out_tready[c];
      end
   end

   // Handshake steering and per-channel output fan-out; reset gates all valid/ready.
   always_comb begin
      axis_md_tready  = !reset && (state == IDLE);
      axis_df_tready  = 1'b0;
      axis_out_tdata  = '0;
      axis_out_tkeep  = '0;
      axis_out_tlast  = '0;
      axis_out_tvalid = '0;
      if (!reset) begin
         unique case (state)
            STREAM:  axis_df_tready = sel_ready;
            DROP:    axis_df_tready = 1'b1;
            default: axis_df_tready = 1'b0;
         endcase
      end
      for (int c = 0; c < NCH; c++) begin
         axis_out_tdata[c*DW +: DW] = axis_df_tdata;
         if (state == STREAM && chan_q == CHW'(c)) begin
            axis_out_tvalid[c]         = axis_df_tvalid && !reset;
            axis_out_tlast[c]          = last_beat;
            axis_out_tkeep[c*KW +: KW] = last_beat ? keep_last : '1;
         end
      end
   end

   // Frame FSM: accepts metadata, counts beats down, and updates the frame counters.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         chan_q         <= '0;
         beats_left     <= '0;
         rem_q          <= '0;
         frames_routed  <= '0;
         frames_dropped <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (axis_md_tvalid) begin
                  chan_q     <= axis_md_tdata[CHW-1:0];
                  beats_left <= beats_next;
                  rem_q      <= rem_next;
                  if (frame_size == 32'd0) begin
                     frames_dropped <= frames_dropped + 32'd1;
                  end else if (axis_md_tdata[7:0] >= 8'(NCH)) begin
                     state <= DROP;
                     busy  <= 1'b1;
                  end else begin
                     state <= STREAM;
                     busy  <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (axis_df_tvalid && sel_ready) begin
                  beats_left <= beats_left - 32'd1;
                  if (last_beat) begin
                     state         <= IDLE;
                     busy          <= 1'b0;
                     frames_routed <= frames_routed + 32'd1;
                  end
               end
            end
            DROP: begin
               if (axis_df_tvalid) begin
                  beats_left <= beats_left - 32'd1;
                  if (last_beat) begin
                     state          <= IDLE;
                     busy           <= 1'b0;
                     frames_dropped <= frames_dropped + 32'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_router.sv
// tb_frame_router: directed table of frames, hand-written reset/wrap/backpressure
// sequences, then randomized frames checked against a transaction-level model.
module tb_frame_router;

   localparam int DW     = 512;
   localparam int NCH    = 4;
   localparam int BPB    = DW / 8;
   localparam int BUDGET = 400;

   typedef struct {
      int           ch;
      logic [DW-1:0] data;
      logic [63:0]  keep;
      bit           last;
   } beat_t;

   typedef struct {
      logic [31:0] size;
      logic [7:0]  md;
      int          beats;
      logic [63:0] last_keep;
      logic [31:0] routed;
      logic [31:0] dropped;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [31:0]          frame_size;
   logic [DW-1:0]        axis_md_tdata;
   logic                 axis_md_tvalid;
   logic                 axis_md_tready;
   logic [DW-1:0]        axis_df_tdata;
   logic                 axis_df_tvalid;
   logic                 axis_df_tready;
   logic [NCH*DW-1:0]    axis_out_tdata;
   logic [NCH*BPB-1:0]   axis_out_tkeep;
   logic [NCH-1:0]       axis_out_tlast;
   logic [NCH-1:0]       axis_out_tvalid;
   logic [NCH-1:0]       axis_out_tready = '1;
   logic                 busy;
   logic [31:0]          frames_routed;
   logic [31:0]          frames_dropped;

   int          n_tests = 0;
   int          n_fail  = 0;
   beat_t       rx_q[$];
   int          valid_cycles = 0;
   int          multi_valid  = 0;
   int          md_busy_viol = 0;
   int          mirror_viol  = 0;
   bit          mirror_on    = 1'b0;
   bit          rdy_random   = 1'b0;
   logic [31:0] m_routed = '0;
   logic [31:0] m_dropped = '0;

   frame_router #(.DW(DW), .NCH(NCH)) dut (
      .clk            (clk),
      .reset          (reset),
      .frame_size     (frame_size),
      .axis_md_tdata  (axis_md_tdata),
      .axis_md_tvalid (axis_md_tvalid),
      .axis_md_tready (axis_md_tready),
      .axis_df_tdata  (axis_df_tdata),
      .axis_df_tvalid (axis_df_tvalid),
      .axis_df_tready (axis_df_tready),
      .axis_out_tdata (axis_out_tdata),
      .axis_out_tkeep (axis_out_tkeep),
      .axis_out_tlast (axis_out_tlast),
      .axis_out_tvalid(axis_out_tvalid),
      .axis_out_tready(axis_out_tready),
      .busy           (busy),
      .frames_routed  (frames_routed),
      .frames_dropped (frames_dropped)
   );

   always #5 clk = ~clk;

   // Sink ready: all-ones, or a fresh random pattern every cycle.
   always @(posedge clk) begin
      #1;
      axis_out_tready = rdy_random ? NCH'($urandom) : '1;
   end

   // Output monitor: records every completed output handshake.
   always @(negedge clk) begin
      int    nv;
      beat_t b;
      nv = 0;
      if (!reset) begin
         for (int c = 0; c < NCH; c++) begin
            if (axis_out_tvalid[c]) nv++;
            if (axis_out_tvalid[c] && axis_out_tready[c]) begin
               b.ch   = c;
               b.data = axis_out_tdata[c*DW +: DW];
               b.keep = axis_out_tkeep[c*BPB +: BPB];
               b.last = axis_out_tlast[c];
               rx_q.push_back(b);
            end
         end
         if (nv > 0) valid_cycles++;
         if (nv > 1) multi_valid++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_data(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got low64 %0h expected low64 %0h", name, got[63:0], exp[63:0]);
      end
   endtask

   task automatic fail(input string name, input int got, input int limit);
      n_tests++;
      n_fail++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, got, limit);
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_md(input logic [31:0] size, input logic [7:0] md, output int waited);
      logic [DW-1:0] w;
      w = rand_word();
      w[7:0] = md;
      axis_md_tdata  = w;
      frame_size     = size;
      axis_md_tvalid = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (axis_md_tready) break;
         waited++;
         if (waited > BUDGET) begin
            fail("md_timeout", waited, BUDGET);
            break;
         end
      end
      tick();
      axis_md_tvalid = 1'b0;
      axis_md_tdata  = rand_word();
      frame_size     = $urandom;   // later changes must not affect the frame in flight
   endtask

   task automatic send_beat(input logic [DW-1:0] d);
      int waited;
      waited = 0;
      axis_df_tdata  = d;
      axis_df_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (axis_md_tready !== 1'b0) md_busy_viol++;
         if (mirror_on && axis_df_tready !== axis_out_tready[1]) mirror_viol++;
         if (axis_df_tready) break;
         waited++;
         if (waited > BUDGET) begin
            fail("df_timeout", waited, BUDGET);
            break;
         end
      end
      tick();
      axis_df_tvalid = 1'b0;
      axis_df_tdata  = rand_word();
   endtask

   // Runs one frame and compares the received beats with the model's beat list.
   task automatic do_frame(input logic [31:0] size, input logic [7:0] md, input bit gaps);
      logic [DW-1:0] src[$];
      beat_t         exp_q[$];
      beat_t         b;
      int            nb;
      int            waited;
      bit            ok;
      nb = int'((64'(size) + 64'(BPB - 1)) / 64'(BPB));
      ok = (size != 0) && (int'(md) < NCH);
      for (int i = 0; i < nb; i++) begin
         b.ch   = int'(md);
         b.data = rand_word();
         b.keep = '0;
         for (int j = 0; j < BPB; j++) b.keep[j] = (64'(i) * 64'(BPB) + 64'(j)) < 64'(size);
         b.last = (64'(i) + 64'd1) * 64'(BPB) >= 64'(size);
         src.push_back(b.data);
         if (ok) exp_q.push_back(b);
      end
      if (ok) m_routed++;
      else m_dropped++;

      rx_q.delete();
      valid_cycles = 0;
      md_busy_viol = 0;
      send_md(size, md, waited);
      for (int i = 0; i < nb; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         send_beat(src[i]);
      end
      @(negedge clk);
      check("busy_after_frame", busy, 0);
      tick();

      check("rx_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         check("beat_chan", rx_q[i].ch, exp_q[i].ch);
         check("beat_keep", rx_q[i].keep, exp_q[i].keep);
         check("beat_last", rx_q[i].last, exp_q[i].last);
         check_data("beat_data", rx_q[i].data, exp_q[i].data);
      end
      check("frames_routed", frames_routed, m_routed);
      check("frames_dropped", frames_dropped, m_dropped);
      if (!ok) check("drop_no_valid", valid_cycles, 0);
      if (nb > 0) check("md_ready_low", md_busy_viol, 0);
   endtask

   initial begin
      vec_t vecs[8];
      int   waited;
      int   lasts;
      logic [31:0] sz;
      logic [7:0]  md;

      vecs[0] = '{32'd4096, 8'd2,   64, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 32'd0};
      vecs[1] = '{32'd100,  8'd0,    2, 64'h0000_000F_FFFF_FFFF, 32'd2, 32'd0};
      vecs[2] = '{32'd128,  8'd5,    0, 64'h0,                   32'd2, 32'd1};
      vecs[3] = '{32'd0,    8'd1,    0, 64'h0,                   32'd2, 32'd2};
      vecs[4] = '{32'd64,   8'd3,    1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd3, 32'd2};
      vecs[5] = '{32'd65,   8'd1,    2, 64'h1,                   32'd4, 32'd2};
      vecs[6] = '{32'd127,  8'd255,  0, 64'h0,                   32'd4, 32'd3};
      vecs[7] = '{32'd1,    8'd2,    1, 64'h1,                   32'd5, 32'd3};

      reset          = 1'b1;
      frame_size     = 32'd64;
      axis_md_tdata  = '0;
      axis_md_tvalid = 1'b1;
      axis_df_tdata  = '0;
      axis_df_tvalid = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("reset_md_ready", axis_md_tready, 0);
      check("reset_df_ready", axis_df_tready, 0);
      check("reset_out_valid", axis_out_tvalid, 0);
      tick();
      reset          = 1'b0;
      axis_md_tvalid = 1'b0;
      axis_df_tvalid = 1'b0;
      @(negedge clk);
      check("init_busy", busy, 0);
      check("init_routed", frames_routed, 0);
      check("init_dropped", frames_dropped, 0);
      check("init_md_ready", axis_md_tready, 1);
      tick();

      // Directed frames with continuous valid/ready.
      for (int v = 0; v < 8; v++) begin
         do_frame(vecs[v].size, vecs[v].md, 1'b0);
         check("tbl_beats", rx_q.size(), vecs[v].beats);
         if (vecs[v].beats > 0) begin
            check("tbl_last_keep", rx_q[rx_q.size()-1].keep, vecs[v].last_keep);
            check("tbl_last_flag", rx_q[rx_q.size()-1].last, 1);
         end
         check("tbl_routed", frames_routed, vecs[v].routed);
         check("tbl_dropped", frames_dropped, vecs[v].dropped);
      end

      // Backpressure on channel 1: df ready must track out1 ready cycle by cycle.
      rdy_random  = 1'b1;
      mirror_on   = 1'b1;
      mirror_viol = 0;
      do_frame(32'd256, 8'd1, 1'b1);
      check("df_ready_mirror", mirror_viol, 0);
      mirror_on   = 1'b0;
      rdy_random  = 1'b0;
      tick();

      // Reset after 10 beats of a 64-beat frame abandons it without tlast.
      rx_q.delete();
      send_md(32'd4096, 8'd3, waited);
      for (int i = 0; i < 10; i++) send_beat(rand_word());
      axis_df_tvalid = 1'b1;
      axis_md_tvalid = 1'b1;
      reset          = 1'b1;
      @(negedge clk);
      check("midrst_md_ready", axis_md_tready, 0);
      check("midrst_df_ready", axis_df_tready, 0);
      check("midrst_out_valid", axis_out_tvalid, 0);
      tick();
      reset          = 1'b0;
      axis_df_tvalid = 1'b0;
      axis_md_tvalid = 1'b0;
      m_routed  = '0;
      m_dropped = '0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_routed", frames_routed, 0);
      check("midrst_dropped", frames_dropped, 0);
      check("midrst_beats", rx_q.size(), 10);
      lasts = 0;
      foreach (rx_q[i]) if (rx_q[i].last) lasts++;
      check("midrst_no_tlast", lasts, 0);
      tick();
      do_frame(32'd64, 8'd1, 1'b0);

      // Zero-length frame with the drop counter preloaded at its maximum.
      force dut.frames_dropped = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.frames_dropped;
      m_dropped = 32'hFFFF_FFFF;
      tick();
      axis_df_tvalid = 1'b1;
      axis_df_tdata  = rand_word();
      send_md(32'd0, 8'd1, waited);
      m_dropped++;
      check("zero_md_wait", waited, 0);
      @(negedge clk);
      check("zero_df_ready", axis_df_tready, 0);
      check("zero_busy", busy, 0);
      check("dropped_wrap", frames_dropped, m_dropped);
      tick();
      axis_df_tvalid = 1'b0;

      // Randomized frames, gaps and backpressure against the model.
      rdy_random = 1'b1;
      for (int n = 0; n < 40; n++) begin
         sz = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 700));
         md = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, NCH - 1));
         do_frame(sz, md, 1'b1);
      end
      rdy_random = 1'b0;

      check("single_valid_channel", multi_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
